// File: rtl/keypad_operand_entry.sv
// keypad_operand_entry
// Turns decoded calculator key presses into a binary operand. Digits build the
// value as value*10+digit, Enter publishes it with a one-cycle strobe, Clear
// discards it. Each key press acts exactly once, on its rising edge.

module keypad_operand_entry #(
  parameter int WORD_LENGTH = 8,
  parameter int MAX_DIGITS  = 3
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 key_valid,
  input  logic [3:0]                           key_code,
  output logic [WORD_LENGTH-1:0]               operand,
  output logic                                 operand_valid,
  output logic                                 overflow,
  output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count
);

  localparam int DCW = $clog2(MAX_DIGITS + 1);
  // Candidate width: operand*10+9 never exceeds WORD_LENGTH+4 bits.
  localparam int CW  = WORD_LENGTH + 4;

  localparam logic [CW-1:0] MAX_VALUE = {4'b0000, {WORD_LENGTH{1'b1}}};

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;

  // EMPTY: nothing entered; ENTRY: digits arriving; HOLD: operand published.
  typedef enum logic [1:0] {
    EMPTY,
    ENTRY,
    HOLD
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic                   key_prev;
  logic                   press;
  logic [CW-1:0]          operand_ext;
  logic [CW-1:0]          candidate;
  logic                   significant;
  logic                   fits;
  logic                   room;
  logic                   accept;
  logic [WORD_LENGTH-1:0] operand_next;
  logic                   valid_next;
  logic                   overflow_next;
  logic [DCW-1:0]         count_next;

  assign press       = key_valid & ~key_prev;
  assign operand_ext = {4'b0000, operand};
  // operand*10 as a shift-add, done wide so an oversized result stays visible.
  assign candidate   = (operand_ext << 3) + (operand_ext << 1) + CW'(key_code);
  // A zero typed while the value is still zero is a leading zero: not counted.
  assign significant = (operand != '0) || (key_code != 4'd0);
  assign fits        = (candidate <= MAX_VALUE);
  assign room        = (digit_count < DCW'(MAX_DIGITS));
  assign accept      = fits && (!significant || room);

  // Key edge detector; preset high so a key held through reset is ignored.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      key_prev <= 1'b1;
    end else begin
      key_prev <= key_valid;
    end
  end

  // State and output registers; outputs are registered so they stay settled
  // for the whole cycle after the edge that changed them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= EMPTY;
      operand       <= '0;
      operand_valid <= 1'b0;
      overflow      <= 1'b0;
      digit_count   <= '0;
    end else begin
      state         <= state_next;
      operand       <= operand_next;
      operand_valid <= valid_next;
      overflow      <= overflow_next;
      digit_count   <= count_next;
    end
  end

  // Next-state and next-output decode for one key press.
  always_comb begin
    // NOTE: every signal gets a default first so no path can leave one
    // unassigned and infer a latch.
    state_next    = state;
    operand_next  = operand;
    valid_next    = 1'b0;
    overflow_next = overflow;
    count_next    = digit_count;

    if (press) begin
      if (key_code <= 4'd9) begin
        if (state == HOLD) begin
          // First digit after a publish starts a fresh number.
          operand_next  = WORD_LENGTH'(key_code);
          count_next    = DCW'(key_code != 4'd0);
          overflow_next = 1'b0;
          state_next    = ENTRY;
        end else if (accept) begin
          operand_next = candidate[WORD_LENGTH-1:0];
          count_next   = significant ? digit_count + 1'b1 : digit_count;
          state_next   = ENTRY;
        end else begin
          // Rejected digit: value kept, flag sticks until Clear/Enter/new number.
          overflow_next = 1'b1;
        end
      end else if (key_code == KEY_ENTER) begin
        valid_next    = 1'b1;
        overflow_next = 1'b0;
        state_next    = HOLD;
      end else if (key_code == KEY_CLEAR) begin
        operand_next  = '0;
        count_next    = '0;
        overflow_next = 1'b0;
        state_next    = EMPTY;
      end
      // Codes C-F consume the edge and do nothing else.
    end
  end

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Testbench for keypad_operand_entry: a directed press table, hand-written
// multi-cycle sequences (long hold, key held through reset, async reset), and
// random presses compared against a decimal-arithmetic reference model.

module tb_keypad_operand_entry;

  localparam int W    = 8;
  localparam int D    = 3;
  localparam int DCW  = $clog2(D + 1);
  localparam int MAXV = (1 << W) - 1;

  logic           clk;
  logic           reset;
  logic           key_valid;
  logic [3:0]     key_code;
  logic [W-1:0]   operand;
  logic           operand_valid;
  logic           overflow;
  logic [DCW-1:0] digit_count;

  int checks   = 0;
  int failures = 0;

  keypad_operand_entry #(
    .WORD_LENGTH(W),
    .MAX_DIGITS (D)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .operand      (operand),
    .operand_valid(operand_valid),
    .overflow     (overflow),
    .digit_count  (digit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] code;
    int         op;
    bit         vld;
    bit         ovf;
    int         cnt;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // One press: key high for 'hold' cycles, then one low cycle. Outputs are
  // sampled on the falling edge just after the press edge; vld_after collects
  // operand_valid over every later sample; op_end is operand at the end.
  task automatic press(input logic [3:0] code, input int hold,
                       output int op, output bit vld, output bit ovf, output int cnt,
                       output bit vld_after, output int op_end);
    @(negedge clk);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge clk);
    op  = int'(operand);
    vld = operand_valid;
    ovf = overflow;
    cnt = int'(digit_count);
    vld_after = 1'b0;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      vld_after |= operand_valid;
    end
    key_valid = 1'b0;
    @(negedge clk);
    vld_after |= operand_valid;
    op_end = int'(operand);
  endtask

  task automatic press_check(input string name, input logic [3:0] code, input int hold,
                             input int e_op, input bit e_vld, input bit e_ovf, input int e_cnt);
    int op, cnt, op_end;
    bit vld, ovf, vld_after;
    press(code, hold, op, vld, ovf, cnt, vld_after, op_end);
    check({name, ".operand"}, op, e_op);
    check({name, ".valid"}, vld, e_vld);
    check({name, ".overflow"}, ovf, e_ovf);
    check({name, ".digits"}, cnt, e_cnt);
    check({name, ".valid_one_cycle"}, vld_after, 1'b0);
    check({name, ".operand_stable"}, op_end, e_op);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Reference model: decimal arithmetic on the value; digit count is simply
  // the number of decimal digits of the value (leading zeros never count).
  int m_val;
  bit m_ovf;
  bit m_published;

  function automatic int ndigits(input int v);
    int n = 0;
    while (v > 0) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  function automatic bit model_press(input int code);
    int nv;
    bit vld = 1'b0;
    if (code <= 9) begin
      if (m_published) begin
        m_val       = code;
        m_ovf       = 1'b0;
        m_published = 1'b0;
      end else begin
        nv = m_val * 10 + code;
        if (nv <= MAXV && ndigits(nv) <= D) m_val = nv;
        else m_ovf = 1'b1;
      end
    end else if (code == 10) begin
      vld         = 1'b1;
      m_ovf       = 1'b0;
      m_published = 1'b1;
    end else if (code == 11) begin
      m_val       = 0;
      m_ovf       = 1'b0;
      m_published = 1'b0;
    end
    return vld;
  endfunction

  vec_t table_v[$];

  initial begin
    int op, cnt, op_end;
    bit vld, ovf, vld_after, e_vld;
    int code;

    reset     = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;

    // Reset state, observed while reset is still asserted.
    #12;
    check("reset.operand", operand, 0);
    check("reset.valid", operand_valid, 0);
    check("reset.overflow", overflow, 0);
    check("reset.digits", digit_count, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed press table: {key, operand, valid, overflow, digit_count}.
    table_v = '{
      '{4'h2, 2,   1'b0, 1'b0, 1}, '{4'h5, 25,  1'b0, 1'b0, 2},
      '{4'h5, 255, 1'b0, 1'b0, 3}, '{4'hA, 255, 1'b1, 1'b0, 3},
      '{4'h2, 2,   1'b0, 1'b0, 1}, '{4'h5, 25,  1'b0, 1'b0, 2},
      '{4'h6, 25,  1'b0, 1'b1, 2}, '{4'hA, 25,  1'b1, 1'b0, 2},
      '{4'hB, 0,   1'b0, 1'b0, 0}, '{4'h0, 0,   1'b0, 1'b0, 0},
      '{4'h0, 0,   1'b0, 1'b0, 0}, '{4'h7, 7,   1'b0, 1'b0, 1},
      '{4'hA, 7,   1'b1, 1'b0, 1}, '{4'h3, 3,   1'b0, 1'b0, 1},
      '{4'h2, 32,  1'b0, 1'b0, 2}, '{4'h1, 32,  1'b0, 1'b1, 2},
      '{4'hA, 32,  1'b1, 1'b0, 2}, '{4'h4, 4,   1'b0, 1'b0, 1},
      '{4'h2, 42,  1'b0, 1'b0, 2}, '{4'hB, 0,   1'b0, 1'b0, 0},
      '{4'hA, 0,   1'b1, 1'b0, 0}, '{4'hA, 0,   1'b1, 1'b0, 0},
      '{4'hC, 0,   1'b0, 1'b0, 0}, '{4'h5, 5,   1'b0, 1'b0, 1},
      '{4'h9, 59,  1'b0, 1'b0, 2}, '{4'h9, 59,  1'b0, 1'b1, 2},
      '{4'hE, 59,  1'b0, 1'b1, 2}, '{4'h1, 59,  1'b0, 1'b1, 2},
      '{4'hB, 0,   1'b0, 1'b0, 0}
    };
    foreach (table_v[i]) begin
      press_check($sformatf("vec%0d", i), table_v[i].code, 1,
                  table_v[i].op, table_v[i].vld, table_v[i].ovf, table_v[i].cnt);
    end

    // Long hold: one digit per press no matter how long the key stays down.
    press_check("hold20", 4'h5, 20, 5, 1'b0, 1'b0, 1);
    press_check("hold_again", 4'h5, 1, 55, 1'b0, 1'b0, 2);

    // Key held through reset release must be ignored until released.
    @(negedge clk);
    key_code  = 4'h7;
    key_valid = 1'b1;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("held_reset.operand", operand, 0);
    check("held_reset.digits", digit_count, 0);
    key_valid = 1'b0;
    @(negedge clk);
    check("held_release.operand", operand, 0);
    press_check("after_held", 4'h1, 1, 1, 1'b0, 1'b0, 1);

    // Asynchronous reset in the middle of a cycle, mid-entry with overflow set.
    press_check("async.b", 4'hB, 1, 0, 1'b0, 1'b0, 0);
    press_check("async.9a", 4'h9, 1, 9, 1'b0, 1'b0, 1);
    press_check("async.9b", 4'h9, 1, 99, 1'b0, 1'b0, 2);
    press_check("async.9c", 4'h9, 1, 99, 1'b0, 1'b1, 2);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async.operand", operand, 0);
    check("async.overflow", overflow, 0);
    check("async.digits", digit_count, 0);
    check("async.valid", operand_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    press_check("async.1", 4'h1, 1, 1, 1'b0, 1'b0, 1);
    press_check("async.A", 4'hA, 1, 1, 1'b1, 1'b0, 1);

    // Random presses against the reference model, starting from reset.
    do_reset();
    m_val       = 0;
    m_ovf       = 1'b0;
    m_published = 1'b0;
    for (int n = 0; n < 400; n++) begin
      int r = $urandom_range(0, 19);
      if (r < 14)       code = $urandom_range(0, 9);
      else if (r < 16)  code = 10;
      else if (r == 16) code = 11;
      else              code = $urandom_range(12, 15);
      press(4'(code), $urandom_range(1, 3), op, vld, ovf, cnt, vld_after, op_end);
      e_vld = model_press(code);
      check($sformatf("rnd%0d.operand", n), op, m_val);
      check($sformatf("rnd%0d.valid", n), vld, e_vld);
      check($sformatf("rnd%0d.overflow", n), ovf, m_ovf);
      check($sformatf("rnd%0d.digits", n), cnt, ndigits(m_val));
      check($sformatf("rnd%0d.valid_one_cycle", n), vld_after, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
# keypad_operand_entry

Converts a stream of decoded calculator key codes into a binary operand for the parameterized operand register. Each new key press is detected on its rising edge. Decimal digits accumulate as value×10+digit; Enter publishes the operand with a one-cycle valid strobe and Clear discards it. Sits directly upstream of the operand register: `operand` feeds its data input and `operand_valid` qualifies the load.

## Interface
- WORD_LENGTH, 8, operand width in bits; maximum value 2^WORD_LENGTH−1.
- MAX_DIGITS, 3, maximum number of significant decimal digits accepted.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  reset, asynchronous, active-low.
- key_valid  input  1  level from the keypad scanner, high while a key is held; synchronous to clk.
- key_code  input  4  decoded key, stable while key_valid is high: 0–9 digit, 4'hA Enter, 4'hB Clear, 4'hC–4'hF ignored.
- operand  output  WORD_LENGTH  accumulated / published value.
- operand_valid  output  1  one-cycle pulse when Enter publishes `operand`.
- overflow  output  1  sticky; a digit was rejected since the last Clear, Enter or new number.
- digit_count  output  $clog2(MAX_DIGITS+1)  significant digits currently held.

## Operation
- Edge detect: `key_prev` register; a press is an edge where key_valid=1 and key_prev=0. Only one action per press, regardless of hold length.
- States: EMPTY (value 0, no digits), ENTRY (digits being entered), HOLD (operand published, waiting).
- Digit d in EMPTY or ENTRY:
  - Candidate = operand×10+d, computed in WORD_LENGTH+4 bits.
  - Accept if candidate ≤ 2^WORD_LENGTH−1 and, for a significant digit, digit_count < MAX_DIGITS.
  - Accept: operand ← candidate; state ← ENTRY.
  - Significant digit: digit_count increments unless operand=0 and d=0, so leading zeros are not counted.
  - Reject: operand and digit_count unchanged; overflow ← 1; state unchanged.
- Digit d in HOLD: starts a new number. operand ← d; digit_count ← (d≠0); overflow ← 0; state ← ENTRY.
- Enter in any state: operand_valid ← 1 for one cycle; operand unchanged; overflow ← 0; state ← HOLD.
  - Enter in EMPTY publishes 0.
  - Enter in HOLD re-publishes the same value.
- Clear in any state: operand ← 0; digit_count ← 0; overflow ← 0; state ← EMPTY; no valid pulse.
- Codes C–F: no effect, but still consume the edge.

## Timing
- Reset (async, reset=0):
  - operand=0, operand_valid=0, overflow=0, digit_count=0, state=EMPTY.
  - key_prev=1, so a key held through reset release is ignored until it is released.
- Latency: edge sampled at rising edge N; operand, digit_count, overflow and operand_valid reflect the action after edge N. This is one cycle.
- operand is stable from that edge until the next accepted action, so a downstream falling-edge register sees settled data.
- operand_valid is high for exactly one cycle per Enter press, including repeated Enters.
- Back-to-back presses: every key_valid low→high transition is processed. Minimum one low cycle between presses.
- key_code is sampled only on the edge cycle; changes while held are ignored.
- Reset asserted mid-entry: all state cleared immediately, with no operand_valid emitted.

## Test plan
- W=8, D=3: presses 2,5,5,A → operand 2, 25, 255 after successive edges; operand_valid one cycle with operand=255; digit_count=3; overflow=0.
- Presses 2,5,6 → 6 rejected: operand=25, overflow=1, digit_count=2. Then A → valid with 25, overflow=0.
- Presses 0,0,7,A → operand 7, digit_count=1. Then 3 (from HOLD) → operand=3, digit_count=1, no valid. Then 2,1,A → 3, 32, 321 rejected (>255), operand_valid with 32.
- Hold key 5 for 20 cycles, release, press 5 again → operand=55 (one digit per press). Key held through reset deassertion → no action.
- Presses 4,2,B → operand=0, digit_count=0, no valid. Then A → valid with 0. Then A again → second valid pulse, still 0.
- Presses 9,9 then reset low mid-cycle → outputs zero asynchronously. After release, press 1,A → valid with 1.
